// File: rtl/pe_mac_acc.sv
// rtl/pe_mac_acc.sv - streaming signed fixed-point MAC with round/saturate formatter (option: PE_ROUND_NEAREST_EN)
module pe_mac_acc #(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9,
  parameter int para_max_len   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [para_int_bits+para_frac_bits-1:0] data_in_1,
  input  logic [para_int_bits+para_frac_bits-1:0] data_in_2,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [para_int_bits+para_frac_bits-1:0] data_out,
  output logic                                  out_sat,
  output logic                                  out_len_err
);

  localparam int W  = para_int_bits + para_frac_bits;
  localparam int F  = para_frac_bits;
  localparam int G  = $clog2(para_max_len);
  localparam int AW = 2 * W + G;

  // Signed W-bit result bounds, sign-extended to accumulator width
  localparam logic signed [AW-1:0] max_v = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] min_v = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [G:0]           last_cnt = (G+1)'(para_max_len - 1);

  logic signed [AW-1:0] acc_q, acc_d;
  logic        [G:0]    cnt_q, cnt_d;
  logic                 first_q, first_d;
  logic                 out_valid_q, out_valid_d;
  logic        [W-1:0]  data_out_q, data_out_d;
  logic                 out_sat_q, out_sat_d;
  logic                 out_len_err_q, out_len_err_d;

  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prod_ext;
  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  rnd;
  logic signed [AW-1:0]  shifted;
  logic        [W-1:0]  fmt_data;
  logic                 fmt_sat;
  logic                 accept;
  logic                 at_limit;
  logic                 end_vec;

  // Single result slot: a new term may enter whenever the slot is empty or draining
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign at_limit = (cnt_q == last_cnt);
  assign end_vec  = in_last || at_limit;

  assign prod     = $signed(data_in_1) * $signed(data_in_2);
  assign prod_ext = {{G{prod[2*W-1]}}, prod};
  assign sum      = (first_q ? '0 : acc_q) + prod_ext;

`ifdef PE_ROUND_NEAREST_EN
  localparam logic signed [AW-1:0] rnd_half = {{(AW-1){1'b0}}, 1'b1} << (F - 1);
  assign rnd = sum + rnd_half;
`else
  assign rnd = sum;
`endif

  assign shifted = rnd >>> F;

  // Clip the rounded dot product to the signed operand range
  always_comb begin
    fmt_data = shifted[W-1:0];
    fmt_sat  = 1'b0;
    if (shifted > max_v) begin
      fmt_data = {1'b0, {(W-1){1'b1}}};
      fmt_sat  = 1'b1;
    end else if (shifted < min_v) begin
      fmt_data = {1'b1, {(W-1){1'b0}}};
      fmt_sat  = 1'b1;
    end
  end

  // Accumulate terms; on the vector-ending term load the result slot and rearm
  always_comb begin
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    out_valid_d   = out_valid_q;
    data_out_d    = data_out_q;
    out_sat_d     = out_sat_q;
    out_len_err_d = out_len_err_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (end_vec) begin
        data_out_d    = fmt_data;
        out_sat_d     = fmt_sat;
        out_len_err_d = at_limit && !in_last;
        out_valid_d   = 1'b1;
        acc_d         = '0;
        cnt_d         = '0;
        first_d       = 1'b1;
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_q + 1'b1;
        first_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any partial vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      first_q       <= 1'b1;
      out_valid_q   <= 1'b0;
      data_out_q    <= '0;
      out_sat_q     <= 1'b0;
      out_len_err_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      out_valid_q   <= out_valid_d;
      data_out_q    <= data_out_d;
      out_sat_q     <= out_sat_d;
      out_len_err_q <= out_len_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign data_out    = data_out_q;
  assign out_sat     = out_sat_q;
  assign out_len_err = out_len_err_q;

endmodule
